// File: rtl/fp8_delta_enc_if.sv
// Handshake bundle between the FP8 delta encoder and its upstream/downstream neighbours.
interface fp8_delta_enc_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_first;
    logic [CNT_W-1:0] out_count;
    logic             nan_seen;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_first, out_count, nan_seen
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_first, out_count, nan_seen
    );
endinterface

// File: rtl/fp8_delta_enc.sv
// Streaming FP8 (E4M3-like) delta encoder y[n] = x[n] - x[n-1] with a combinational FP8 subtractor.
// Optional sticky NaN flag enabled by defining FP8_DELTA_NAN_STICKY_EN.
module fp8_sub_top (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);
    // Both operands become exact signed integers in units of 2^-9, the subnormal step.
    function automatic logic signed [18:0] to_fixed(input logic [7:0] v);
        logic [3:0]  sig;
        logic [3:0]  sh;
        logic [17:0] mag;
        sig = {(v[6:3] != 4'd0), v[2:0]};
        sh  = (v[6:3] == 4'd0) ? 4'd0 : v[6:3] - 4'd1;
        mag = 18'(sig) << sh;
        return v[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    function automatic logic [7:0] round_pack(input logic signed [18:0] d);
        logic [17:0] mag;
        logic [17:0] rem;
        logic [17:0] half;
        logic [4:0]  lead;
        logic [4:0]  sh;
        logic [4:0]  sig;
        logic [4:0]  expf;
        logic [6:0]  mag7;
        mag  = d[18] ? 18'(-d) : d[17:0];
        lead = 5'd0;
        for (int i = 0; i < 18; i++) begin
            if (mag[i]) lead = 5'(i);
        end
        if (mag < 18'd16) begin
            mag7 = mag[6:0];
        end else begin
            sh   = lead - 5'd3;
            sig  = 5'(mag >> sh);
            rem  = mag & ((18'd1 << sh) - 18'd1);
            half = 18'd1 << (sh - 5'd1);
            if ((rem > half) || ((rem == half) && sig[0])) sig = sig + 5'd1;
            expf = sh + 5'd1;
            if (sig[4]) begin
                sig  = 5'd8;
                expf = expf + 5'd1;
            end
            mag7 = (expf >= 5'd15) ? 7'h77 : {expf[3:0], sig[2:0]};
        end
        return (mag7 == 7'd0) ? 8'h00 : {d[18], mag7};
    endfunction

    always_comb begin
        if ((a[6:3] == 4'hF) || (b[6:3] == 4'hF)) y = 8'h7F;
        else y = round_pack(to_fixed(a) - to_fixed(b));
    end
endmodule

module fp8_delta_enc #(
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    fp8_delta_enc_if.slave bus
);
    typedef enum logic {ST_FIRST, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       prev_q, prev_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_first_q, out_first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready, accept, out_hs, first_op;
    logic [7:0]       sub_b, sub_y;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign out_hs   = out_valid_q && bus.out_ready;
    // A sample arriving with restart is treated as the head of a new run.
    assign first_op = (state_q == ST_FIRST) || restart;
    assign sub_b    = first_op ? 8'h00 : prev_q;

    fp8_sub_top u_sub (
        .a (bus.in_data),
        .b (sub_b),
        .y (sub_y)
    );

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        cnt_d       = cnt_q;
        if (out_hs) begin
            out_valid_d = 1'b0;
            cnt_d       = cnt_q + 1'b1;
        end
        if (restart) begin
            state_d = ST_FIRST;
            prev_d  = 8'h00;
            cnt_d   = '0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sub_y;
            out_first_d = first_op;
            prev_d      = bus.in_data;
            state_d     = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FIRST;
            prev_q      <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_first_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef FP8_DELTA_NAN_STICKY_EN
    logic nan_q, nan_d;

    always_comb begin
        nan_d = nan_q;
        if (restart) nan_d = 1'b0;
        else if (out_hs && (out_data_q == 8'h7F)) nan_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) nan_q <= 1'b0;
        else     nan_q <= nan_d;
    end

    assign bus.nan_seen = nan_q;
`else
    assign bus.nan_seen = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_first = out_first_q;
    assign bus.out_count = cnt_q;
endmodule
